// File: rtl/xbee_telemetry_tx_pkg.sv
// rtl/xbee_telemetry_tx_pkg.sv - shared types and constants for the Xbee telemetry transmitter
package xbee_telemetry_tx_pkg;

  // Frame-level sequencing states of the top controller
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } tx_state_e;

  // Bit phases of the byte serializer
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } tx_phase_e;

  localparam int         FRAME_LEN         = 6;
  localparam logic [7:0] FRAME_HDR_DEFAULT = 8'hA5;

  // Frame check byte over the four payload bytes
  function automatic logic [7:0] frame_chk(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    return a ^ b ^ c ^ d;
  endfunction

endpackage

// File: rtl/xbee_telemetry_tx_uart_tx_byte.sv
// rtl/xbee_telemetry_tx_uart_tx_byte.sv - 8N1 byte serializer with a bit-period divider
module uart_tx_byte
  import xbee_telemetry_tx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tvalid,
  input  logic [7:0] i_tdata,
  output logic       o_tready,
  output logic       o_txd,
  output logic       o_bit_end,
  output logic       o_last_data,
  output logic       o_stop_early,
  output logic       o_done
);

  localparam int            CW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_EARLY = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  tx_phase_e     r_phase;
  logic [CW-1:0] r_div_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;

  logic          w_bit_end;
  logic          w_load;

  assign w_bit_end    = (r_phase != PH_IDLE) && (r_div_cnt == CNT_LAST);
  // The final stop-bit cycle also accepts, so a queued byte follows with no idle gap.
  assign o_tready     = (r_phase == PH_IDLE) || ((r_phase == PH_STOP) && w_bit_end);
  assign w_load       = i_tvalid && o_tready;
  assign o_txd        = r_txd;
  assign o_bit_end    = w_bit_end;
  assign o_last_data  = (r_bit_idx == 3'd7);
  // One clock before the stop bit ends: lets the framer request the next byte in time.
  assign o_stop_early = (r_phase == PH_STOP) && (r_div_cnt == CNT_EARLY);
  assign o_done       = (r_phase == PH_STOP) && w_bit_end;

  // Walk start, data (LSB first) and stop bits, each held DIV clocks, from a registered line
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase   <= PH_IDLE;
      r_div_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else if (w_load) begin
      r_phase   <= PH_START;
      r_div_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= i_tdata;
      r_txd     <= 1'b0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          r_txd <= 1'b1;
        end
        PH_START: begin
          if (w_bit_end) begin
            r_phase   <= PH_DATA;
            r_div_cnt <= '0;
            r_txd     <= r_shift[0];
          end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
          end
        end
        PH_DATA: begin
          if (w_bit_end) begin
            r_div_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_phase <= PH_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
          end
        end
        PH_STOP: begin
          if (w_bit_end) begin
            r_phase   <= PH_IDLE;
            r_div_cnt <= '0;
            r_txd     <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
          end
        end
        default: begin
          r_phase <= PH_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/xbee_telemetry_tx.sv
// rtl/xbee_telemetry_tx.sv - six-byte telemetry framer with CTS flow control toward an Xbee radio
module xbee_telemetry_tx
  import xbee_telemetry_tx_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 9600,
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_en,
  input  logic [7:0] sensors,
  input  logic [7:0] lmdist,
  input  logic [7:0] rmdist,
  input  logic [7:0] motctl,
  input  logic       nCTS,
  output logic       uart_out,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);

  localparam int         DIV       = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN);

  tx_state_e  r_state;
  tx_state_e  w_next_state;

  logic       r_cts_meta;
  logic       r_cts_sync;
  logic       r_busy;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_sensors;
  logic [7:0] r_lmdist;
  logic [7:0] r_rmdist;
  logic [7:0] r_motctl;
  logic [7:0] r_chk;
  logic [2:0] r_byte_idx;

  logic       w_accept;
  logic       w_more_bytes;
  logic       w_tx_valid;
  logic [7:0] w_tx_data;
  logic       w_tx_ready;
  logic       w_txd;
  logic       w_bit_end;
  logic       w_last_data;
  logic       w_stop_early;
  logic       w_byte_done;

  assign w_accept     = send_en && !r_busy;
  // r_byte_idx counts bytes already handed to the serializer.
  assign w_more_bytes = (r_byte_idx != LAST_BYTE);

  assign uart_out   = w_txd;
  assign busy       = r_busy;
  assign frame_done = (r_state == ST_DONE);
  assign drop_cnt   = r_drop_cnt;

  // Two-flop synchronizer for the asynchronous clear-to-send; idles as "not clear"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= nCTS;
      r_cts_sync <= r_cts_meta;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Frame FSM next state; START/DATA/STOP track the serializer's bit phases.
  // For non-final bytes STOP hands over one clock early so WAIT_CTS overlaps the
  // last stop-bit clock and the next start bit follows back-to-back.
  always_comb begin
    w_next_state = r_state;
    w_tx_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_WAIT_CTS;
      end
      ST_WAIT_CTS: begin
        if (!r_cts_sync && w_tx_ready) begin
          w_tx_valid   = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && w_last_data) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_more_bytes) begin
          if (w_stop_early) w_next_state = ST_WAIT_CTS;
        end else if (w_byte_done) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Snapshot payload and checksum at acceptance, track busy, byte index and drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
      r_sensors  <= '0;
      r_lmdist   <= '0;
      r_rmdist   <= '0;
      r_motctl   <= '0;
      r_chk      <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_sensors  <= sensors;
        r_lmdist   <= lmdist;
        r_rmdist   <= rmdist;
        r_motctl   <= motctl;
        r_chk      <= frame_chk(sensors, lmdist, rmdist, motctl);
        r_byte_idx <= '0;
      end else begin
        if (r_state == ST_DONE) r_busy <= 1'b0;
        if (w_tx_valid) r_byte_idx <= r_byte_idx + 3'd1;
      end
      if (send_en && r_busy && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Select the frame byte to hand to the serializer next
  always_comb begin
    w_tx_data = FRAME_HDR;
    case (r_byte_idx)
      3'd0:    w_tx_data = FRAME_HDR;
      3'd1:    w_tx_data = r_sensors;
      3'd2:    w_tx_data = r_lmdist;
      3'd3:    w_tx_data = r_rmdist;
      3'd4:    w_tx_data = r_motctl;
      default: w_tx_data = r_chk;
    endcase
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_byte (
    .i_clk        (clk),
    .i_reset_n    (reset),
    .i_tvalid     (w_tx_valid),
    .i_tdata      (w_tx_data),
    .o_tready     (w_tx_ready),
    .o_txd        (w_txd),
    .o_bit_end    (w_bit_end),
    .o_last_data  (w_last_data),
    .o_stop_early (w_stop_early),
    .o_done       (w_byte_done)
  );

endmodule

// File: tb/tb_xbee_telemetry_tx.sv
// tb/tb_xbee_telemetry_tx.sv - self-checking bench for xbee_telemetry_tx
module tb_xbee_telemetry_tx;

  localparam int DIV       = 10;
  localparam int BYTE_CLKS = 10 * DIV;

  typedef struct {
    logic [7:0] s;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] m;
    logic [7:0] chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_en = 1'b0;
  logic [7:0] sensors = '0;
  logic [7:0] lmdist = '0;
  logic [7:0] rmdist = '0;
  logic [7:0] motctl = '0;
  logic       nCTS = 1'b0;
  logic       uart_out;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vec_t tbl [5];

  xbee_telemetry_tx #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .FRAME_HDR (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_en    (send_en),
    .sensors    (sensors),
    .lmdist     (lmdist),
    .rmdist     (rmdist),
    .motctl     (motctl),
    .nCTS       (nCTS),
    .uart_out   (uart_out),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Wait for a start bit, then sample each bit mid-period; optionally raise nCTS k clocks in.
  task automatic rx_byte(input int max_wait, input int raise_at,
                         output logic [7:0] b, output int fall_at, output bit ok);
    int waited;
    bit start_ok;
    bit stop_ok;
    b = '0; fall_at = -1; ok = 1'b0; waited = 0; start_ok = 1'b0; stop_ok = 1'b0;
    while (uart_out !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (uart_out === 1'b0) begin
      fall_at = cyc;
      for (int k = 1; k <= 10 * DIV - DIV / 2; k++) begin
        @(negedge clk);
        if (k == raise_at) nCTS = 1'b1;
        if (k % DIV == DIV / 2) begin
          if (k / DIV == 0)      start_ok = (uart_out === 1'b0);
          else if (k / DIV == 9) stop_ok  = (uart_out === 1'b1);
          else                   b[3'(k / DIV - 1)] = uart_out;
        end
      end
      ok = start_ok && stop_ok;
    end
  endtask

  task automatic start_frame(input string tag, input logic [7:0] s, input logic [7:0] l,
                             input logic [7:0] r, input logic [7:0] m, output int acc);
    sensors = s; lmdist = l; rmdist = r; motctl = m;
    send_en = 1'b1;
    @(negedge clk);
    send_en = 1'b0;
    acc = cyc;
    check({tag, "_busy_on_accept"}, busy, 1);
    check({tag, "_line_idle_at_accept"}, uart_out, 1);
  endtask

  task automatic recv_frame(input string tag, input logic [0:5][7:0] exp_b, input int exp_fall0,
                            input int first_wait, input int hold_idx, input bit drop_in_done,
                            output int fall0);
    logic [7:0] b;
    int fall_at;
    int prev_fall;
    int early;
    int w;
    bit ok;
    bit seen;
    bit resume;
    prev_fall = -1; fall0 = -1; resume = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_byte((i == 0) ? first_wait : 2 * BYTE_CLKS, (i == hold_idx) ? 3 * DIV : -1, b, fall_at, ok);
      check($sformatf("%s_byte%0d_framing", tag, i), ok, 1);
      check($sformatf("%s_byte%0d_data", tag, i), b, exp_b[i]);
      if (i == 0) begin
        fall0 = fall_at;
        if (exp_fall0 >= 0) check($sformatf("%s_first_fall_cycle", tag), fall0, exp_fall0);
      end else if (!resume) begin
        check($sformatf("%s_byte%0d_spacing", tag, i), fall_at - prev_fall, BYTE_CLKS);
      end
      resume = 1'b0;
      prev_fall = fall_at;
      if (i == hold_idx) begin
        early = 0;
        repeat (BYTE_CLKS) begin
          @(negedge clk);
          if (uart_out !== 1'b1 || busy !== 1'b1) early++;
        end
        check($sformatf("%s_byte%0d_withheld", tag, i + 1), early, 0);
        nCTS = 1'b0;
        resume = 1'b1;
      end
    end
    seen = 1'b0;
    for (w = 0; w < 2 * DIV && !seen; w++) begin
      @(negedge clk);
      seen = (frame_done === 1'b1);
    end
    check({tag, "_frame_done_seen"}, seen, 1);
    check({tag, "_frame_done_after_last_start"}, cyc - prev_fall, BYTE_CLKS);
    if (drop_in_done) send_en = 1'b1;
    @(negedge clk);
    send_en = 1'b0;
    check({tag, "_busy_clear_after_done"}, busy, 0);
    check({tag, "_frame_done_one_cycle"}, frame_done, 0);
  endtask

  initial begin
    int acc;
    int f0;
    int rel;
    int low_seen;
    int fa;
    int w;
    bit ok;
    logic [7:0] b;
    logic [0:5][7:0] e;

    tbl[0] = '{s: 8'h1F, l: 8'h40, r: 8'h02, m: 8'h33, chk: 8'h6E};
    tbl[1] = '{s: 8'h00, l: 8'h00, r: 8'h00, m: 8'h00, chk: 8'h00};
    tbl[2] = '{s: 8'h12, l: 8'h34, r: 8'h56, m: 8'h78, chk: 8'h08};
    tbl[3] = '{s: 8'h01, l: 8'h02, r: 8'h04, m: 8'h08, chk: 8'h0F};
    tbl[4] = '{s: 8'hFF, l: 8'hFF, r: 8'hFF, m: 8'hFF, chk: 8'h00};

    repeat (3) @(negedge clk);
    check("reset_uart_out", uart_out, 1);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_frame(tag, tbl[i].s, tbl[i].l, tbl[i].r, tbl[i].m, acc);
      e = {8'hA5, tbl[i].s, tbl[i].l, tbl[i].r, tbl[i].m, tbl[i].chk};
      recv_frame(tag, e, acc + 1, 4, -1, 1'b0, f0);
      repeat (3) @(negedge clk);
    end
    check("no_drops_after_table", drop_cnt, 0);

    nCTS = 1'b1;
    repeat (4) @(negedge clk);
    start_frame("cts_start", 8'hAA, 8'h55, 8'hF0, 8'h0E, acc);
    low_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_out !== 1'b1 || busy !== 1'b1) low_seen++;
    end
    check("cts_start_line_held", low_seen, 0);
    nCTS = 1'b0;
    rel = cyc;
    e = {8'hA5, 8'hAA, 8'h55, 8'hF0, 8'h0E, 8'h01};
    recv_frame("cts_start", e, -1, 3, -1, 1'b1, f0);
    check("cts_release_latency_le3", (f0 > rel) && (f0 - rel <= 3), 1);
    check("drop_in_done_counted", drop_cnt, 1);
    repeat (3) @(negedge clk);

    start_frame("cts_mid", 8'h11, 8'h22, 8'h44, 8'h88, acc);
    e = {8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
    recv_frame("cts_mid", e, acc + 1, 4, 1, 1'b0, f0);
    check("cts_mid_drop_cnt", drop_cnt, 1);
    repeat (3) @(negedge clk);

    start_frame("drop", 8'h5A, 8'hA5, 8'h3C, 8'h81, acc);
    sensors = 8'h00; lmdist = 8'hFF; rmdist = 8'h77; motctl = 8'hEE;
    e = {8'hA5, 8'h5A, 8'hA5, 8'h3C, 8'h81, 8'h42};
    fork
      recv_frame("drop", e, acc + 1, 4, -1, 1'b0, f0);
      begin
        for (int p = 0; p < 300; p++) begin
          send_en = 1'b1;
          @(negedge clk);
          send_en = 1'b0;
          @(negedge clk);
        end
      end
    join
    check("drop_cnt_saturated", drop_cnt, 8'hFF);
    repeat (3) @(negedge clk);

    start_frame("rst", 8'hC3, 8'h3C, 8'hA0, 8'h5A, acc);
    e = {8'hA5, 8'hC3, 8'h3C, 8'hA0, 8'h5A, 8'h05};
    for (int i = 0; i < 3; i++) begin
      rx_byte((i == 0) ? 4 : 2 * BYTE_CLKS, -1, b, fa, ok);
      check($sformatf("rst_byte%0d_data", i), b, e[i]);
    end
    w = 0;
    while (uart_out !== 1'b0 && w < 2 * BYTE_CLKS) begin
      @(negedge clk);
      w++;
    end
    check("rst_byte3_started", uart_out, 0);
    repeat (4 * DIV + 2) @(negedge clk);
    check("rst_pre_bit3_low", uart_out, 0);
    check("rst_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_uart_out", uart_out, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_drop_cnt", drop_cnt, 0);
    check("rst_async_frame_done", frame_done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_line_idle", uart_out, 1);
    start_frame("fresh", 8'h1F, 8'h40, 8'h02, 8'h33, acc);
    e = {8'hA5, 8'h1F, 8'h40, 8'h02, 8'h33, 8'h6E};
    recv_frame("fresh", e, acc + 1, 4, -1, 1'b0, f0);
    check("fresh_drop_cnt", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbee_telemetry_tx.md
XBEE_TELEMETRY_TX -- requirements
Module: xbee_telemetry_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter FRAME_HDR, default 8'hA5, first byte of every frame.
REQ-004 clk  in  1  100 MHz system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 send_en  in  1  one-cycle frame request strobe.
REQ-007 sensors  in  8  packed sensor byte, sampled at frame acceptance.
REQ-008 lmdist  in  8  left rangefinder distance, sampled at acceptance.
REQ-009 rmdist  in  8  right rangefinder distance, sampled at acceptance.
REQ-010 motctl  in  8  active motor control byte, sampled at acceptance.
REQ-011 nCTS  in  1  Xbee clear-to-send, active-low, asynchronous to clk.
REQ-012 uart_out  out  1  serial 8N1 line to Xbee, idle high.
REQ-013 busy  out  1  high from frame acceptance until frame_done.
REQ-014 frame_done  out  1  one-cycle pulse after the last stop bit of a frame.
REQ-015 drop_cnt  out  8  count of send_en requests rejected while busy.

Function
REQ-016 Bit period SHALL be DIV = CLK_HZ/BAUD clocks (integer truncation), 10416 at defaults.
REQ-017 A frame SHALL be 6 bytes in order: FRAME_HDR, sensors, lmdist, rmdist, motctl, CHK.
REQ-018 CHK SHALL equal sensors XOR lmdist XOR rmdist XOR motctl, using the snapshot values.
REQ-019 send_en high while busy=0 SHALL snapshot all four data inputs and set busy on the same edge.
REQ-020 send_en high while busy=1 SHALL be ignored; drop_cnt increments by 1 and saturates at 255.
REQ-021 Each byte SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each lasting exactly DIV clocks.
REQ-022 nCTS SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-023 A byte SHALL start only while synchronized nCTS = 0; once started, it completes regardless of nCTS.
REQ-024 With nCTS steady low, uart_out SHALL fall on the clock edge after acceptance, and bytes SHALL be back-to-back with no idle gap.
REQ-025 The FSM SHALL have the states IDLE, WAIT_CTS, START, DATA, STOP, and DONE.
REQ-026 FSM transitions:
- IDLE->WAIT_CTS on acceptance.
- WAIT_CTS->START when CTS is clear.
- START->DATA after DIV clocks.
- DATA->STOP after 8 bit periods.
- STOP->WAIT_CTS after DIV clocks if bytes remain, otherwise STOP->DONE.
- DONE->IDLE after one cycle.
REQ-027 frame_done SHALL be high only in DONE; busy SHALL clear on the DONE->IDLE edge.
REQ-028 A send_en arriving in the DONE cycle SHALL be counted as dropped.
REQ-029 uart_out SHALL be driven from a register with no combinational glitches.

Reset
REQ-030 reset low SHALL immediately force the following, including mid-byte: uart_out=1, busy=0, frame_done=0, drop_cnt=0, FSM=IDLE, counters=0, synchronizer=1.
REQ-031 After reset deasserts, the first frame SHALL begin with a full start bit.

Structure
REQ-032 The shared package SHALL hold the FSM state enum, FRAME_LEN=6, and the default FRAME_HDR constant.
REQ-033 Byte serialization SHALL live in one sub-module, uart_tx_byte (start/8 data/stop, DIV counter, ready/done handshake).
REQ-034 Framing, snapshot, checksum, CTS gating, and drop counting SHALL stay in the top module.

Verification (CLK_HZ=1000, BAUD=100, DIV=10)
REQ-035 Data and framing: sensors=1F, lmdist=40, rmdist=02, motctl=33, nCTS=0, then pulse send_en. Required: bytes A5 1F 40 02 33 6E on uart_out, frame_done exactly 600 clocks after uart_out falls, busy low the next cycle.
REQ-036 CTS hold at start: nCTS=1 before send_en. Required: busy=1 and uart_out stays 1 for 100 clocks; release nCTS and uart_out falls within 3 clocks.
REQ-037 CTS hold mid-frame: raise nCTS during byte 2 data bits. Required: byte 2 completes intact, byte 3 withheld while nCTS=1, then resumes.
REQ-038 Drop counting and snapshot: pulse send_en 300 times while busy, and change all inputs after acceptance. Required: drop_cnt=255 and the original frame bytes are transmitted.
REQ-039 Reset mid-byte: assert reset during byte 4 bit 3. Required: uart_out=1, busy=0, drop_cnt=0 the same cycle, then a fresh full frame after the next send_en.
